// File: rtl/qcw_pkg.sv
// Shared types, widths and helpers for the QCW burst sequencer.
// The accumulator is unsigned 8.8 fixed point; its integer byte drives the PLL phase shift.
package qcw_pkg;

  localparam int ACCUM_W = 16;
  localparam int FRAC_W  = 8;
  localparam int CNT_W   = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_GAP,
    ST_HOLD
  } qcw_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Sum is one bit wider than the accumulator so a large step can never wrap below the ceiling.
  function automatic logic [ACCUM_W-1:0] ramp_next(input logic [ACCUM_W-1:0]        acc,
                                                   input logic [ACCUM_W-1:0]        step,
                                                   input logic [ACCUM_W-FRAC_W-1:0] ceil_int);
    logic [ACCUM_W:0] sum;
    logic [ACCUM_W:0] ceil_fx;
    sum     = {1'b0, acc} + {1'b0, step};
    ceil_fx = {1'b0, ceil_int, {FRAC_W{1'b0}}};
    return (sum > ceil_fx) ? ceil_fx[ACCUM_W-1:0] : sum[ACCUM_W-1:0];
  endfunction

endpackage

// File: rtl/qcw_edge_rise.sv
// Registered rising-edge detector for the sticky PLL status flags.
// Reset samples the current level so a flag already high through reset is not seen as a new edge.
module qcw_edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= sig;
      rise  <= 1'b0;
    end else begin
      sig_q <= sig;
      rise  <= sig & ~sig_q;
    end
  end

endmodule

// File: rtl/qcw_burst_ctrl.sv
// QCW burst sequencer: issues PLL start, cycle limit and a per-RF-cycle phase ramp,
// enforces the burst repetition period, and converts overcurrent/faults into halt and holdoff.
module qcw_burst_ctrl
  import qcw_pkg::*;
#(
  parameter int BURST_PERIOD  = 1_000_000,
  parameter int FAULT_HOLDOFF = 5_000_000,
  parameter int WATCHDOG      = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  ramp_start,
  input  logic [7:0]  ramp_end,
  input  logic [15:0] ramp_step,
  input  logic [15:0] burst_cycles,
  input  logic        ocp,
  input  logic        pll_cycle_finished,
  input  logic        pll_done,
  input  logic        pll_fault,
  output logic        pll_start,
  output logic        pll_halt,
  output logic [7:0]  phase_shift,
  output logic [15:0] cycle_limit,
  output logic        burst_active,
  output logic        fault_latched
);

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(BURST_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(FAULT_HOLDOFF - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT    = CNT_W'(WATCHDOG);

  qcw_state_t         state;
  logic [ACCUM_W-1:0] accum;
  logic [CNT_W-1:0]   period_cnt;
  logic [CNT_W-1:0]   wd_cnt;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   period_next;
  logic [CNT_W-1:0]   wd_next;
  logic               cyc_rise;
  logic               done_rise;
  logic               fault_rise;

  qcw_edge_rise u_cyc_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (pll_cycle_finished),
    .rise (cyc_rise)
  );

  qcw_edge_rise u_done_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (pll_done),
    .rise (done_rise)
  );

  qcw_edge_rise u_fault_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (pll_fault),
    .rise (fault_rise)
  );

  assign period_next = sat_inc(period_cnt, PERIOD_LAST);
  assign wd_next     = sat_inc(wd_cnt, WD_LIMIT);
  assign phase_shift = accum[ACCUM_W-1:FRAC_W];

  // pll_start is registered in START, so the pulse lands on the first RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      accum         <= '0;
      period_cnt    <= '0;
      wd_cnt        <= '0;
      hold_cnt      <= '0;
      cycle_limit   <= '0;
      pll_start     <= 1'b0;
      pll_halt      <= 1'b0;
      burst_active  <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      pll_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state         <= ST_START;
            accum         <= {ramp_start, {FRAC_W{1'b0}}};
            cycle_limit   <= burst_cycles;
            fault_latched <= 1'b0;
            period_cnt    <= '0;
            wd_cnt        <= '0;
            burst_active  <= 1'b1;
          end
        end

        ST_START: begin
          state      <= ST_RUN;
          pll_start  <= 1'b1;
          period_cnt <= period_next;
        end

        ST_RUN: begin
          period_cnt <= period_next;
          wd_cnt     <= wd_next;
          if (cyc_rise) begin
            accum <= ramp_next(accum, ramp_step, ramp_end);
          end
          // A fault outranks a coincident done so the holdoff is never skipped.
          if (fault_rise) begin
            state         <= ST_HOLD;
            hold_cnt      <= '0;
            fault_latched <= 1'b1;
            pll_halt      <= 1'b0;
            burst_active  <= 1'b0;
          end else if (done_rise) begin
            state        <= ST_GAP;
            pll_halt     <= 1'b0;
            burst_active <= 1'b0;
          end else if (ocp || (wd_next == WD_LIMIT)) begin
            pll_halt <= 1'b1;
          end
        end

        ST_GAP: begin
          period_cnt <= period_next;
          if (period_next == PERIOD_LAST) begin
            state <= ST_IDLE;
          end
        end

        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qcw_burst_ctrl.sv
// Directed bench for qcw_burst_ctrl: table of ramp bursts plus hand sequences for
// repetition period, overcurrent/fault holdoff, coincident flags, watchdog and reset.
module tb_qcw_burst_ctrl;

  localparam int BP = 1000;
  localparam int FH = 300;
  localparam int WD = 500;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  ramp_start;
  logic [7:0]  ramp_end;
  logic [15:0] ramp_step;
  logic [15:0] burst_cycles;
  logic        ocp;
  logic        pll_cycle_finished;
  logic        pll_done;
  logic        pll_fault;
  logic        pll_start;
  logic        pll_halt;
  logic [7:0]  phase_shift;
  logic [15:0] cycle_limit;
  logic        burst_active;
  logic        fault_latched;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  typedef struct {
    logic [7:0]  r_start;
    logic [7:0]  r_end;
    logic [15:0] r_step;
    logic [15:0] cycles;
    int          pulses;
    logic [7:0]  exp_phase;
  } ramp_vec_t;

  localparam int NVEC = 11;
  ramp_vec_t vecs[NVEC];

  qcw_burst_ctrl #(
    .BURST_PERIOD  (BP),
    .FAULT_HOLDOFF (FH),
    .WATCHDOG      (WD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .ramp_start         (ramp_start),
    .ramp_end           (ramp_end),
    .ramp_step          (ramp_step),
    .burst_cycles       (burst_cycles),
    .ocp                (ocp),
    .pll_cycle_finished (pll_cycle_finished),
    .pll_done           (pll_done),
    .pll_fault          (pll_fault),
    .pll_start          (pll_start),
    .pll_halt           (pll_halt),
    .phase_shift        (phase_shift),
    .cycle_limit        (cycle_limit),
    .burst_active       (burst_active),
    .fault_latched      (fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitStart(input string name, input int budget, output int n);
    logic seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      tick();
      n++;
      seen = pll_start;
    end
    checkOutput({name, "_start_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_pll_start"},     {31'd0, pll_start},     32'd0);
    checkOutput({name, "_pll_halt"},      {31'd0, pll_halt},      32'd0);
    checkOutput({name, "_burst_active"},  {31'd0, burst_active},  32'd0);
    checkOutput({name, "_fault_latched"}, {31'd0, fault_latched}, 32'd0);
    checkOutput({name, "_phase_shift"},   {24'd0, phase_shift},   32'd0);
    checkOutput({name, "_cycle_limit"},   {16'd0, cycle_limit},   32'd0);
  endtask

  task automatic applyStimulus(input ramp_vec_t v, input int idx);
    int    n;
    string tag;
    tag          = $sformatf("vec%0d", idx);
    ramp_start   = v.r_start;
    ramp_end     = v.r_end;
    ramp_step    = v.r_step;
    burst_cycles = v.cycles;
    enable       = 1'b1;
    waitStart(tag, 3 * BP, n);
    if (idx == 0) checkOutput("start_latency", n, 2);
    enable       = 1'b0;
    burst_cycles = ~v.cycles;
    tick();
    checkOutput({tag, "_start_width"}, {31'd0, pll_start}, 32'd0);
    for (int p = 0; p < v.pulses; p++) begin
      pll_cycle_finished = 1'b1;
      tick();
      pll_cycle_finished = 1'b0;
      tick();
    end
    tick();
    checkOutput({tag, "_phase"},       {24'd0, phase_shift}, {24'd0, v.exp_phase});
    checkOutput({tag, "_cycle_limit"}, {16'd0, cycle_limit}, {16'd0, v.cycles});
    checkOutput({tag, "_active"},      {31'd0, burst_active}, 32'd1);
    pll_done = 1'b1;
    ticks(2);
    checkOutput({tag, "_gap"}, {31'd0, burst_active}, 32'd0);
    pll_done = 1'b0;
    ticks(2);
    checkOutput({tag, "_phase_hold"}, {24'd0, phase_shift}, {24'd0, v.exp_phase});
  endtask

  initial begin
    int n;
    int t0;
    int t1;
    int starts;

    vecs[0]  = '{8'd10,  8'd200, 16'h0280, 16'd100,    0,   8'd10};
    vecs[1]  = '{8'd10,  8'd200, 16'h0280, 16'd100,    1,   8'd12};
    vecs[2]  = '{8'd10,  8'd200, 16'h0280, 16'd100,    2,   8'd15};
    vecs[3]  = '{8'd10,  8'd200, 16'h0280, 16'd100,    3,   8'd17};
    vecs[4]  = '{8'd10,  8'd200, 16'h0280, 16'd100,    75,  8'd197};
    vecs[5]  = '{8'd10,  8'd200, 16'h0280, 16'd100,    76,  8'd200};
    vecs[6]  = '{8'd10,  8'd200, 16'h0280, 16'd100,    100, 8'd200};
    vecs[7]  = '{8'd50,  8'd20,  16'h0100, 16'd7,      1,   8'd20};
    vecs[8]  = '{8'd250, 8'd255, 16'hFFFF, 16'hFFFF,   1,   8'd255};
    vecs[9]  = '{8'd0,   8'd255, 16'h0055, 16'd1,      4,   8'd1};
    vecs[10] = '{8'd5,   8'd255, 16'h0180, 16'd3,      3,   8'd9};

    rst                = 1'b1;
    enable             = 1'b0;
    ramp_start         = 8'd0;
    ramp_end           = 8'd0;
    ramp_step          = 16'd0;
    burst_cycles       = 16'd0;
    ocp                = 1'b0;
    pll_cycle_finished = 1'b0;
    pll_done           = 1'b0;
    pll_fault          = 1'b0;

    ticks(3);
    rst = 1'b0;
    checkAllZero("reset");

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

    $display("[TB] repetition period");
    ramp_start   = 8'd10;
    ramp_end     = 8'd200;
    ramp_step    = 16'h0280;
    burst_cycles = 16'd100;
    enable       = 1'b1;
    waitStart("rep_first", 3 * BP, n);
    t0 = cyc;
    ticks(3);
    pll_done = 1'b1;
    ticks(3);
    pll_done = 1'b0;
    waitStart("rep_second", 3 * BP, n);
    t1 = cyc;
    checkOutput("rep_period", t1 - t0, BP);
    ticks(5);
    enable = 1'b0;
    ticks(3);
    checkOutput("rep_not_aborted", {31'd0, burst_active}, 32'd1);
    pll_done = 1'b1;
    ticks(3);
    pll_done = 1'b0;
    checkOutput("rep_done_gap", {31'd0, burst_active}, 32'd0);
    starts = 0;
    for (int i = 0; i < 2 * BP; i++) begin
      tick();
      if (pll_start) starts++;
    end
    checkOutput("rep_no_restart", starts, 0);

    $display("[TB] overcurrent and fault holdoff");
    enable = 1'b1;
    waitStart("ocp", 10, n);
    checkOutput("ocp_start_latency", n, 2);
    enable = 1'b0;
    ticks(3);
    checkOutput("ocp_halt_before", {31'd0, pll_halt}, 32'd0);
    ocp = 1'b1;
    tick();
    checkOutput("ocp_halt_next", {31'd0, pll_halt}, 32'd1);
    ocp = 1'b0;
    ticks(4);
    checkOutput("ocp_halt_held", {31'd0, pll_halt}, 32'd1);
    pll_fault = 1'b1;
    tick();
    checkOutput("fault_edge_still_run", {31'd0, burst_active}, 32'd1);
    tick();
    checkOutput("fault_hold_active", {31'd0, burst_active}, 32'd0);
    checkOutput("fault_halt_dropped", {31'd0, pll_halt}, 32'd0);
    checkOutput("fault_latched", {31'd0, fault_latched}, 32'd1);
    pll_fault = 1'b0;
    enable    = 1'b1;
    starts    = 0;
    for (int i = 0; i < FH; i++) begin
      tick();
      if (pll_start) starts++;
    end
    checkOutput("hold_no_start", starts, 0);
    checkOutput("hold_fault_latched", {31'd0, fault_latched}, 32'd1);
    waitStart("hold_exit", 10, n);
    checkOutput("hold_exit_latency", n, 2);
    checkOutput("fault_cleared_on_start", {31'd0, fault_latched}, 32'd0);

    $display("[TB] coincident done and fault");
    enable = 1'b0;
    ticks(3);
    pll_done  = 1'b1;
    pll_fault = 1'b1;
    ticks(2);
    checkOutput("coinc_fault_latched", {31'd0, fault_latched}, 32'd1);
    checkOutput("coinc_active", {31'd0, burst_active}, 32'd0);
    pll_done  = 1'b0;
    pll_fault = 1'b0;
    enable    = 1'b1;
    ticks(FH);
    waitStart("coinc_hold_exit", 10, n);
    checkOutput("coinc_hold_latency", n, 2);

    $display("[TB] watchdog");
    enable = 1'b0;
    ticks(WD - 1);
    checkOutput("wd_before_limit", {31'd0, pll_halt}, 32'd0);
    tick();
    checkOutput("wd_at_limit", {31'd0, pll_halt}, 32'd1);
    ticks(5);
    checkOutput("wd_held", {31'd0, pll_halt}, 32'd1);

    $display("[TB] reset mid-run");
    rst      = 1'b1;
    pll_done = 1'b1;
    tick();
    rst = 1'b0;
    checkAllZero("midrun_reset");
    enable = 1'b1;
    waitStart("post_reset", 10, n);
    checkOutput("post_reset_latency", n, 2);
    enable = 1'b0;
    ticks(20);
    checkOutput("sticky_done_ignored", {31'd0, burst_active}, 32'd1);
    pll_done = 1'b0;
    tick();
    pll_done = 1'b1;
    ticks(2);
    checkOutput("post_reset_done", {31'd0, burst_active}, 32'd0);
    pll_done = 1'b0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
